// File: rtl/bitop_alu_pkg.sv
// Shared opcodes, FSM encoding and width helpers for the sequential bit-op ALU.
// CLZ/CTZ support is enabled by defining BITOP_ALU_CLZ_EN.
package bitop_alu_pkg;

  localparam logic [2:0] OP_PARITY = 3'b000;
  localparam logic [2:0] OP_POPCNT = 3'b001;
  localparam logic [2:0] OP_ROTR   = 3'b010;
  localparam logic [2:0] OP_ROTL   = 3'b011;
  localparam logic [2:0] OP_CLZ    = 3'b100;
  localparam logic [2:0] OP_CTZ    = 3'b101;
  localparam logic [2:0] OP_BREV   = 3'b110;
  localparam logic [2:0] OP_RSVD   = 3'b111;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_BUSY = 2'b01;
  localparam logic [1:0] ST_DONE = 2'b10;

  function automatic int nchunk_f(input int dw, input int cw);
    return dw / cw;
  endfunction

  function automatic int cnt_w_f(input int w);
    return $clog2(w + 1);
  endfunction

  function automatic int idx_w_f(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bitop_chunk_reduce.sv
// Combinational reductions over one CHUNK_WIDTH slice of the operand.
// Zero-count outputs exist only when BITOP_ALU_CLZ_EN is defined.
module bitop_chunk_reduce
  import bitop_alu_pkg::*;
#(
  parameter int CHUNK_WIDTH = 64,
  localparam int CW_W = cnt_w_f(CHUNK_WIDTH)
) (
  input  logic [CHUNK_WIDTH-1:0] chunk,
  output logic                   parity,
`ifdef BITOP_ALU_CLZ_EN
  output logic [CW_W-1:0]        lzc,
  output logic [CW_W-1:0]        tzc,
  output logic                   all_zero,
`endif
  output logic [CW_W-1:0]        pop
);

  always_comb begin
    parity = ^chunk;
    pop    = '0;
    for (int i = 0; i < CHUNK_WIDTH; i++)
      pop = pop + CW_W'(chunk[i]);
  end

`ifdef BITOP_ALU_CLZ_EN
  logic seen_l;
  logic seen_t;

  always_comb begin
    lzc    = '0;
    tzc    = '0;
    seen_l = 1'b0;
    seen_t = 1'b0;
    for (int i = 0; i < CHUNK_WIDTH; i++) begin
      if (!seen_l) begin
        if (chunk[CHUNK_WIDTH-1-i]) seen_l = 1'b1;
        else lzc = lzc + CW_W'(1);
      end
      if (!seen_t) begin
        if (chunk[i]) seen_t = 1'b1;
        else tzc = tzc + CW_W'(1);
      end
    end
    all_zero = ~|chunk;
  end
`endif

endmodule

// File: rtl/bitop_alu_seq.sv
// Handshaked bit-manipulation ALU; reductions iterate one chunk per cycle.
// Define BITOP_ALU_CLZ_EN to implement CLZ/CTZ, otherwise they are illegal.
module bitop_alu_seq
  import bitop_alu_pkg::*;
#(
  parameter int DATA_WIDTH  = 1024,
  parameter int CHUNK_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [2:0]            opcode,
  input  logic [DATA_WIDTH-1:0] A_in,
  input  logic [DATA_WIDTH-1:0] B_in,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] Alu_out,
  output logic                  illegal_op,
  output logic                  out_valid,
  input  logic                  out_ready
);

  localparam int NCHUNK = nchunk_f(DATA_WIDTH, CHUNK_WIDTH);
  localparam int PW     = cnt_w_f(DATA_WIDTH);
  localparam int CPW    = cnt_w_f(CHUNK_WIDTH);
  localparam int SW     = $clog2(DATA_WIDTH);
  localparam int IW     = idx_w_f(NCHUNK);
  localparam logic [IW-1:0] LAST = IW'(NCHUNK - 1);

  logic [1:0]            state;
  logic [2:0]            op_q;
  logic [DATA_WIDTH-1:0] a_q;
  logic [SW-1:0]         b_q;
  logic [IW-1:0]         cnt;
  logic                  acc_par;
  logic [PW-1:0]         acc_pop;

  logic [IW-1:0]          idx;
  logic [CHUNK_WIDTH-1:0] chunk;
  logic                   c_par;
  logic [CPW-1:0]         c_pop;
  logic                   is_reduce;
  logic                   last;
  logic                   par_nx;
  logic [PW-1:0]          pop_nx;

  logic [2*DATA_WIDTH-1:0] dbl_r;
  logic [2*DATA_WIDTH-1:0] dbl_l;
  logic [DATA_WIDTH-1:0]   rotr;
  logic [DATA_WIDTH-1:0]   rotl;
  logic [DATA_WIDTH-1:0]   brev;
  logic [DATA_WIDTH-1:0]   res;
  logic                    ill;

  logic unused_b;
  assign unused_b = ^B_in[DATA_WIDTH-1:SW];

  assign in_ready  = (state == ST_IDLE) & rst_n;
  assign out_valid = (state == ST_DONE);

`ifdef BITOP_ALU_CLZ_EN
  logic [PW-1:0]  acc_zc;
  logic           found;
  logic [CPW-1:0] c_lzc;
  logic [CPW-1:0] c_tzc;
  logic           c_zero;
  logic [PW-1:0]  zc_nx;
  logic           found_nx;

  // CLZ walks chunks from the top, everything else from the bottom
  assign idx = (op_q == OP_CLZ) ? LAST - cnt : cnt;
  assign is_reduce = (op_q == OP_PARITY) | (op_q == OP_POPCNT) |
                     (op_q == OP_CLZ) | (op_q == OP_CTZ);

  always_comb begin
    zc_nx    = acc_zc;
    found_nx = found | ~c_zero;
    if (!found)
      zc_nx = acc_zc + ((op_q == OP_CLZ) ? PW'(c_lzc) : PW'(c_tzc));
  end
`else
  assign idx = cnt;
  assign is_reduce = (op_q == OP_PARITY) | (op_q == OP_POPCNT);
`endif

  assign chunk = CHUNK_WIDTH'(a_q >> (int'(idx) * CHUNK_WIDTH));

  bitop_chunk_reduce #(
    .CHUNK_WIDTH(CHUNK_WIDTH)
  ) u_reduce (
    .chunk    (chunk),
    .parity   (c_par),
`ifdef BITOP_ALU_CLZ_EN
    .lzc      (c_lzc),
    .tzc      (c_tzc),
    .all_zero (c_zero),
`endif
    .pop      (c_pop)
  );

  assign last   = !is_reduce || (cnt == LAST);
  assign par_nx = acc_par ^ c_par;
  assign pop_nx = acc_pop + PW'(c_pop);

  assign dbl_r = {a_q, a_q} >> b_q;
  assign dbl_l = {a_q, a_q} << b_q;
  assign rotr  = dbl_r[DATA_WIDTH-1:0];
  assign rotl  = dbl_l[2*DATA_WIDTH-1:DATA_WIDTH];

  always_comb begin
    brev = '0;
    for (int i = 0; i < DATA_WIDTH; i++)
      brev[i] = a_q[DATA_WIDTH-1-i];
  end

  always_comb begin
    res = '0;
    ill = 1'b0;
    unique case (1'b1)
      op_q == OP_PARITY: res = DATA_WIDTH'(par_nx);
      op_q == OP_POPCNT: res = DATA_WIDTH'(pop_nx);
      op_q == OP_ROTR:   res = rotr;
      op_q == OP_ROTL:   res = rotl;
      op_q == OP_BREV:   res = brev;
`ifdef BITOP_ALU_CLZ_EN
      op_q == OP_CLZ:    res = DATA_WIDTH'(zc_nx);
      op_q == OP_CTZ:    res = DATA_WIDTH'(zc_nx);
`endif
      default:           ill = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      cnt        <= '0;
      acc_par    <= 1'b0;
      acc_pop    <= '0;
      Alu_out    <= '0;
      illegal_op <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (in_valid) begin
            state   <= ST_BUSY;
            op_q    <= opcode;
            a_q     <= A_in;
            b_q     <= B_in[SW-1:0];
            cnt     <= '0;
            acc_par <= 1'b0;
            acc_pop <= '0;
          end
        end
        ST_BUSY: begin
          if (last) begin
            state      <= ST_DONE;
            Alu_out    <= res;
            illegal_op <= ill;
          end else begin
            cnt     <= cnt + IW'(1);
            acc_par <= par_nx;
            acc_pop <= pop_nx;
          end
        end
        ST_DONE: begin
          if (out_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef BITOP_ALU_CLZ_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_zc <= '0;
      found  <= 1'b0;
    end else if (state == ST_IDLE && in_valid) begin
      acc_zc <= '0;
      found  <= 1'b0;
    end else if (state == ST_BUSY && !last) begin
      acc_zc <= zc_nx;
      found  <= found_nx;
    end
  end
`endif

endmodule

// File: doc/bitop_alu_seq.md
# bitop_alu_seq

Sequential, handshaked successor to the combinational bit-manipulation ALU. It performs parity, popcount, rotate-right/left, bit-reverse and (optionally) leading/trailing-zero count on a DATA_WIDTH operand. Reductions are processed CHUNK_WIDTH bits per cycle, so the wide reduction trees are replaced by a small iterative datapath. It sits between an operand-issue stage and a result consumer using valid/ready on both sides.

## Interface
- DATA_WIDTH, 1024: operand/result width; power of two, ≥ CHUNK_WIDTH.
- CHUNK_WIDTH, 64: bits reduced per cycle; power of two; DATA_WIDTH % CHUNK_WIDTH == 0. NCHUNK = DATA_WIDTH/CHUNK_WIDTH.
- clk  in  1  rising-edge clock; single clock domain.
- rst_n  in  1  asynchronous, active-low reset.
- opcode  in  3  operation, sampled on accept.
- A_in  in  DATA_WIDTH  data operand.
- B_in  in  DATA_WIDTH  rotate amount; only low log2(DATA_WIDTH) bits used.
- in_valid  in  1  request valid.
- in_ready  out  1  block idle, can accept.
- Alu_out  out  DATA_WIDTH  result; scalar results zero-extended.
- illegal_op  out  1  result corresponds to an unsupported opcode.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.

## Operation
- Opcodes: 000 PARITY, 001 POPCOUNT, 010 ROTR, 011 ROTL, 100 CLZ, 101 CTZ, 110 BREV, 111 reserved.
- FSM: IDLE → BUSY on in_valid & in_ready; the edge latches opcode, A_in, B_in and clears the chunk counter and accumulator. BUSY → DONE after the final step. DONE → IDLE on out_valid & out_ready.
- PARITY: XOR of all bits; result is 0 or 1.
- POPCOUNT: accumulator is clog2(DATA_WIDTH+1) bits wide. All-ones input yields DATA_WIDTH with no overflow.
- CLZ: scans chunks from the MSB chunk. CTZ: scans from the LSB chunk. A zero operand yields DATA_WIDTH. Scanning stops counting once the first 1 is found, but still runs all NCHUNK steps.
- ROTR/ROTL: amount = B_in mod DATA_WIDTH. Amount 0 returns A_in unchanged.
- BREV: Alu_out[i] = A_in[DATA_WIDTH-1-i].
- Reserved opcode (111): Alu_out = 0, illegal_op = 1.
- illegal_op is 0 for all defined opcodes.

## Timing
- Reduction ops (PARITY, POPCOUNT, CLZ, CTZ) run NCHUNK BUSY steps. ROTR, ROTL, BREV and reserved run 1 step.
- out_valid rises exactly NCHUNK (or 1) clock edges after the accept edge.
- in_ready = (state == IDLE) and is forced low while rst_n is low. in_valid is ignored in BUSY and DONE.
- Alu_out and illegal_op are registered. They hold stable while out_valid & !out_ready, for any duration.
- The completing handshake edge returns the FSM to IDLE, so the next accept is at the following edge at the earliest. There is no same-cycle result/accept overlap.
- Minimum issue interval is NCHUNK+2 cycles for reductions and 3 cycles for single-step ops.
- Reset values: state IDLE, Alu_out 0, illegal_op 0, out_valid 0, counter 0, accumulator 0.
- Reset asserted mid-BUSY or in DONE discards the operation immediately. No partial result is ever presented.
- Operand changes on A_in/B_in after accept have no effect.

## Configuration
- BITOP_ALU_CLZ_EN defined: CLZ and CTZ are implemented as described above.
- Undefined: opcodes 100 and 101 behave as reserved: single step, Alu_out = 0, illegal_op = 1. The zero-count logic is not synthesised.

## Structure
- bitop_alu_pkg holds the opcode localparams, the FSM state encoding (IDLE/BUSY/DONE), and the NCHUNK and count-width derivation functions.
- bitop_chunk_reduce is a combinational sub-module operating on one CHUNK_WIDTH slice. It returns parity, popcount, leading-zero count, trailing-zero count and an all-zero flag. The top module contains the FSM, the chunk mux, the accumulators and the rotate/reverse datapath.

## Test plan
All scenarios use DATA_WIDTH=256, CHUNK_WIDTH=64 (NCHUNK=4), with out_ready=1 unless stated.
1. PARITY, A=8'b10101100 → Alu_out=0, out_valid 4 edges after accept. A=8'b10101101 → Alu_out=1.
2. POPCOUNT, A=8'b11101101 → 6. A=all ones → 256. illegal_op=0 in both cases.
3. ROTR, A=8'b10101101, B=3 → Alu_out[255:253]=3'b101, Alu_out[4:0]=5'b10101, all other bits 0, latency 1. B=259 → identical result. ROTL, A={8'b10101101, 248'b0}, B=3 → Alu_out[255:251]=5'b01101, Alu_out[2:0]=3'b101.
4. With BITOP_ALU_CLZ_EN: CLZ A=0 → 256; CTZ A=1<<100 → 100; CLZ A=1<<200 → 55. Without the macro: opcode 100 → Alu_out=0, illegal_op=1, latency 1.
5. Backpressure: hold out_ready=0 for 5 cycles while pulsing in_valid with a new opcode. Required: Alu_out stable, in_ready=0, no new accept; after out_ready=1 the FSM is IDLE on the next cycle.
6. Assert rst_n low during BUSY step 2 of a POPCOUNT. Required: out_valid=0 and Alu_out=0 immediately. After release, BREV A=1 → Alu_out=1<<255.
